cpu_sequencer: RTL and testbench

Parametrised instruction-sequencing core for the Computer12 processor family. Owns the instruction pointer, the pointer registers, the fetch/immediate/execute cadence, memory wait-state handling and vectored interrupt entry. The external instruction decoder and ALU connect through the `dec_*` and `ptr_*` ports.

---
 rtl/cpu_seq_if.sv | 52 +++++
 rtl/cpu_sequencer.sv | 179 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_if.sv
// cpu_seq_if: memory, decoder, pointer-write and interrupt signals of the
// Computer12 instruction sequencer. The master modport is the sequencer side.
interface cpu_seq_if #(
  parameter int WORD = 12,
  parameter int NPTR = 3,
  parameter int NIRQ = 24
);
  localparam int AW = 2*WORD;
  localparam int PW = (NPTR > 1) ? $clog2(NPTR) : 1;
  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  logic [NIRQ-1:0] irq;
  logic            mem_ready;
  logic [WORD-1:0] data_in;
  logic [AW-1:0]   address;
  logic            mem_write;
  logic [3:0]      state;
  logic [WORD-1:0] instr;
  logic [WORD-1:0] imm;
  logic            dec_has_imm;
  logic            dec_mem_access;
  logic            dec_mem_write;
  logic            dec_reti;
  logic            dec_ei;
  logic            dec_di;
  logic [PW-1:0]   dec_ptr_sel;
  logic            jump_en;
  logic [AW-1:0]   jump_target;
  logic            ptr_we;
  logic [PW-1:0]   ptr_sel;
  logic            ptr_half;
  logic [WORD-1:0] ptr_wdata;
  logic            ie;
  logic            irq_ack;
  logic [IW-1:0]   irq_id;

  modport master (
    input  irq, mem_ready, data_in,
    input  dec_has_imm, dec_mem_access, dec_mem_write, dec_reti, dec_ei, dec_di,
    input  dec_ptr_sel, jump_en, jump_target,
    input  ptr_we, ptr_sel, ptr_half, ptr_wdata,
    output address, mem_write, state, instr, imm, ie, irq_ack, irq_id
  );

  modport slave (
    output irq, mem_ready, data_in,
    output dec_has_imm, dec_mem_access, dec_mem_write, dec_reti, dec_ei, dec_di,
    output dec_ptr_sel, jump_en, jump_target,
    output ptr_we, ptr_sel, ptr_half, ptr_wdata,
    input  address, mem_write, state, instr, imm, ie, irq_ack, irq_id
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: Computer12 instruction sequencing core. Owns IP, pointer
// registers, FETCH/IMM/EXEC cadence, memory wait states and vectored
// interrupt entry. Define CPU_SEQ_IRQ_EN to build the IRQ state, EPC, ie and
// the reti/ei/di handling; without it irq is ignored and ie/irq_ack/irq_id are 0.
module cpu_sequencer #(
  parameter int              WORD     = 12,
  parameter int              NPTR     = 3,
  parameter int              NIRQ     = 24,
  parameter logic [2*WORD-1:0] VEC_BASE = '0
) (
  input logic       clk,
  input logic       rst,
  cpu_seq_if.master bus
);
  localparam int AW = 2*WORD;
  localparam int PW = (NPTR > 1) ? $clog2(NPTR) : 1;
  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [3:0] {
    S_FETCH = 4'b0001,
    S_IMM   = 4'b0010,
    S_EXEC  = 4'b0100,
    S_IRQ   = 4'b1000
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           ip_q, ip_d;
  logic [NPTR-1:0][AW-1:0] ptr_q, ptr_d;
  logic [WORD-1:0]         instr_q, instr_d;
  logic [WORD-1:0]         imm_q, imm_d;
  logic [AW-1:0]           ptr_rd;
  logic                    exec_done;

`ifdef CPU_SEQ_IRQ_EN
  logic [AW-1:0] epc_q, epc_d;
  logic          ie_q, ie_d;
  logic          irq_ack_q, irq_ack_d;
  logic [IW-1:0] irq_id_q, irq_id_d;
  logic [IW-1:0] irq_low;
  logic          irq_any;

  // Lowest-index pending request wins.
  always_comb begin
    irq_low = '0;
    for (int i = NIRQ-1; i >= 0; i--)
      if (bus.irq[i]) irq_low = IW'(i);
  end
  assign irq_any = |bus.irq;
`else
  wire unused_irq = &{1'b0, bus.irq, bus.dec_reti, bus.dec_ei, bus.dec_di};
`endif

  // EXEC address mux; an out-of-range selector matches nothing and reads 0.
  always_comb begin
    ptr_rd = '0;
    for (int i = 0; i < NPTR; i++)
      if (bus.dec_ptr_sel == PW'(i)) ptr_rd = ptr_q[i];
  end

  assign exec_done = !bus.dec_mem_access || bus.mem_ready;

  // Next-state and register updates for the instruction cadence.
  always_comb begin
    state_d = state_q;
    ip_d    = ip_q;
    ptr_d   = ptr_q;
    instr_d = instr_q;
    imm_d   = imm_q;
`ifdef CPU_SEQ_IRQ_EN
    epc_d     = epc_q;
    ie_d      = ie_q;
    irq_ack_d = 1'b0;
    irq_id_d  = irq_id_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          instr_d = bus.data_in;
          ip_d    = ip_q + AW'(1);
          state_d = S_IMM;
        end
      end
      S_IMM: begin
        if (!bus.dec_has_imm) begin
          state_d = S_EXEC;
        end else if (bus.mem_ready) begin
          imm_d   = bus.data_in;
          ip_d    = ip_q + AW'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          // Pointer write lands next cycle, so this cycle's address saw the old value.
          if (bus.ptr_we) begin
            for (int i = 0; i < NPTR; i++) begin
              if (bus.ptr_sel == PW'(i)) begin
                if (bus.ptr_half) ptr_d[i][AW-1:WORD] = bus.ptr_wdata;
                else              ptr_d[i][WORD-1:0]  = bus.ptr_wdata;
              end
            end
          end
`ifdef CPU_SEQ_IRQ_EN
          if (bus.dec_reti) begin
            ip_d = epc_q;
            ie_d = 1'b1;
          end else if (bus.jump_en) begin
            ip_d = bus.jump_target;
          end
          if (bus.dec_ei) ie_d = 1'b1;
          if (bus.dec_di) ie_d = 1'b0;
          state_d = (ie_d && irq_any) ? S_IRQ : S_FETCH;
`else
          if (bus.jump_en) ip_d = bus.jump_target;
          state_d = S_FETCH;
`endif
        end
      end
      S_IRQ: begin
`ifdef CPU_SEQ_IRQ_EN
        // A request that vanished before this cycle is simply dropped.
        if (irq_any) begin
          epc_d     = ip_q;
          ip_d      = VEC_BASE + AW'(irq_low);
          ie_d      = 1'b0;
          irq_ack_d = 1'b1;
          irq_id_d  = irq_low;
        end
`endif
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      ip_q    <= '0;
      ptr_q   <= '0;
      instr_q <= '0;
      imm_q   <= '0;
`ifdef CPU_SEQ_IRQ_EN
      epc_q     <= '0;
      ie_q      <= 1'b0;
      irq_ack_q <= 1'b0;
      irq_id_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      ptr_q   <= ptr_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
`ifdef CPU_SEQ_IRQ_EN
      epc_q     <= epc_d;
      ie_q      <= ie_d;
      irq_ack_q <= irq_ack_d;
      irq_id_q  <= irq_id_d;
`endif
    end
  end

  assign bus.address   = (state_q == S_EXEC) ? ptr_rd : ip_q;
  assign bus.mem_write = (state_q == S_EXEC) && bus.dec_mem_write && bus.dec_mem_access;
  assign bus.state     = state_q;
  assign bus.instr     = instr_q;
  assign bus.imm       = imm_q;
`ifdef CPU_SEQ_IRQ_EN
  assign bus.ie      = ie_q;
  assign bus.irq_ack = irq_ack_q;
  assign bus.irq_id  = irq_id_q;
`else
  assign bus.ie      = 1'b0;
  assign bus.irq_ack = 1'b0;
  assign bus.irq_id  = '0;
`endif
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: drives instruction-level scenarios and random programs,
// predicting every cycle from a program-order model of the sequencer.
module tb_cpu_sequencer;
  localparam logic [23:0] VEC = 24'o00000100;
`ifdef CPU_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [3:0] ST_F = 4'b0001, ST_I = 4'b0010, ST_E = 4'b0100, ST_Q = 4'b1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_seq_if #(.WORD(12), .NPTR(3), .NIRQ(24)) bus ();
  cpu_sequencer #(.WORD(12), .NPTR(3), .NIRQ(24), .VEC_BASE(VEC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    bit has_imm, acc, wr, reti, ei, di, jmp, pwe, phalf, irq_drop, abort;
    logic [1:0]  dps, psel;
    logic [23:0] jt;
    logic [11:0] pwd, imm_data;
    int wf, wi, we;
  } ins_t;

  int n_cmp = 0, n_err = 0;

  logic [23:0] m_ip, m_epc;
  logic [23:0] m_ptr [3];
  logic [11:0] m_instr, m_imm;
  logic        m_ie, m_ack;
  logic [4:0]  m_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [23:0] v);
    for (int i = 0; i < 24; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_ip = '0; m_epc = '0; m_instr = '0; m_imm = '0; m_ie = 1'b0; m_ack = 1'b0; m_id = '0;
    for (int i = 0; i < 3; i++) m_ptr[i] = '0;
  endtask

  // Check one cycle at the falling edge, then advance past the next rising edge.
  task automatic cyc(input logic [3:0] st, input bit ck_addr, input logic [23:0] addr, input logic mw);
    @(negedge clk);
    chk("state", 32'(bus.state), 32'(st));
    if (ck_addr) chk("address", 32'(bus.address), 32'(addr));
    chk("mem_write", 32'(bus.mem_write), 32'(mw));
    chk("instr", 32'(bus.instr), 32'(m_instr));
    chk("imm", 32'(bus.imm), 32'(m_imm));
    chk("ie", 32'(bus.ie), 32'(m_ie));
    chk("irq_ack", 32'(bus.irq_ack), 32'(m_ack));
    if (m_ack) chk("irq_id", 32'(bus.irq_id), 32'(m_id));
    @(posedge clk); #1;
    m_ack = 1'b0;
  endtask

  task automatic run(input ins_t s);
    logic [11:0] d;
    logic [23:0] ea;
    logic        mw;
    int          id;
    bus.dec_has_imm = s.has_imm;  bus.dec_mem_access = s.acc; bus.dec_mem_write = s.wr;
    bus.dec_reti = s.reti; bus.dec_ei = s.ei; bus.dec_di = s.di; bus.dec_ptr_sel = s.dps;
    bus.jump_en = s.jmp; bus.jump_target = s.jt;
    bus.ptr_we = s.pwe; bus.ptr_sel = s.psel; bus.ptr_half = s.phalf; bus.ptr_wdata = s.pwd;
    // FETCH
    for (int w = 0; w < s.wf; w++) begin
      bus.mem_ready = 1'b0; bus.data_in = 12'($urandom);
      cyc(ST_F, 1'b1, m_ip, 1'b0);
    end
    d = 12'($urandom); bus.mem_ready = 1'b1; bus.data_in = d;
    cyc(ST_F, 1'b1, m_ip, 1'b0);
    m_instr = d; m_ip = m_ip + 24'd1;
    // IMM
    if (s.has_imm) begin
      for (int w = 0; w < s.wi; w++) begin
        bus.mem_ready = 1'b0; bus.data_in = 12'($urandom);
        cyc(ST_I, 1'b1, m_ip, 1'b0);
      end
      bus.mem_ready = 1'b1; bus.data_in = s.imm_data;
      cyc(ST_I, 1'b1, m_ip, 1'b0);
      m_imm = s.imm_data; m_ip = m_ip + 24'd1;
    end else begin
      bus.mem_ready = 1'($urandom); bus.data_in = 12'($urandom);
      cyc(ST_I, 1'b1, m_ip, 1'b0);
    end
    // EXEC
    ea = (s.dps < 2'd3) ? m_ptr[s.dps] : 24'd0;
    mw = s.wr & s.acc;
    if (s.acc) begin
      for (int w = 0; w < s.we; w++) begin
        bus.mem_ready = 1'b0;
        if (s.abort) rst = 1'b0;
        cyc(ST_E, 1'b1, ea, mw);
        if (s.abort) begin
          model_reset();
          rst = 1'b1;
          cyc(ST_F, 1'b1, 24'd0, 1'b0);
          return;
        end
      end
    end
    bus.mem_ready = s.acc ? 1'b1 : 1'($urandom);
    cyc(ST_E, 1'b1, ea, mw);
    if (s.pwe && s.psel < 2'd3) begin
      if (s.phalf) m_ptr[s.psel][23:12] = s.pwd;
      else         m_ptr[s.psel][11:0]  = s.pwd;
    end
    if (IRQ_EN && s.reti) begin
      m_ip = m_epc; m_ie = 1'b1;
    end else if (s.jmp) m_ip = s.jt;
    if (IRQ_EN && s.ei) m_ie = 1'b1;
    if (IRQ_EN && s.di) m_ie = 1'b0;
    // Interrupt entry
    if (IRQ_EN && m_ie && bus.irq != 24'd0) begin
      if (s.irq_drop) bus.irq = 24'd0;
      cyc(ST_Q, 1'b0, 24'd0, 1'b0);
      if (bus.irq != 24'd0) begin
        id = lowest(bus.irq);
        m_epc = m_ip; m_ip = VEC + 24'(id); m_ie = 1'b0; m_ack = 1'b1; m_id = 5'(id);
      end
    end
  endtask

  function automatic ins_t blank();
    ins_t s;
    s = '{default: 0};
    return s;
  endfunction

  initial begin
    ins_t s;
    rst = 1'b0;
    bus.irq = '0; bus.mem_ready = 1'b0; bus.data_in = '0;
    bus.dec_has_imm = 0; bus.dec_mem_access = 0; bus.dec_mem_write = 0;
    bus.dec_reti = 0; bus.dec_ei = 0; bus.dec_di = 0; bus.dec_ptr_sel = '0;
    bus.jump_en = 0; bus.jump_target = '0;
    bus.ptr_we = 0; bus.ptr_sel = '0; bus.ptr_half = 0; bus.ptr_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cyc(ST_F, 1'b1, 24'd0, 1'b0);   // still in reset: reset state visible
    @(negedge clk);
    chk("rst_irq_id", 32'(bus.irq_id), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Plain instruction, no immediate, all ready.
    s = blank(); run(s);
    // Immediate with two wait states.
    s = blank(); s.has_imm = 1; s.wi = 2; s.imm_data = 12'o1234; run(s);
    s = blank(); s.has_imm = 1; s.imm_data = 12'o7070; s.wf = 1; run(s);
    // Build pointer 0 = 0o01234567, then store through it.
    s = blank(); s.pwe = 1; s.psel = 0; s.phalf = 0; s.pwd = 12'o4567; run(s);
    s = blank(); s.pwe = 1; s.psel = 0; s.phalf = 1; s.pwd = 12'o0123; run(s);
    s = blank(); s.acc = 1; s.wr = 1; s.dps = 0; s.we = 1; run(s);
    // Write the same pointer used as the address: old value on the bus.
    s = blank(); s.acc = 1; s.dps = 0; s.pwe = 1; s.psel = 0; s.pwd = 12'o7777; run(s);
    s = blank(); s.acc = 1; s.wr = 1; s.dps = 0; run(s);
    // Out-of-range selectors: write ignored, read 0.
    s = blank(); s.pwe = 1; s.psel = 3; s.pwd = 12'o5555; run(s);
    s = blank(); s.acc = 1; s.wr = 1; s.dps = 3; run(s);
    s = blank(); s.pwe = 1; s.psel = 2; s.phalf = 1; s.pwd = 12'o3456; run(s);
    s = blank(); s.acc = 1; s.dps = 2; s.we = 2; run(s);
    // Interrupt entry: IP = 0o42 after EXEC, irq bits 3 and 5.
    bus.irq = 24'h000028;
    s = blank(); s.ei = 1; s.jmp = 1; s.jt = 24'o00000042; run(s);
    bus.irq = 24'd0;
    s = blank(); run(s);
    // Return with a competing jump.
    s = blank(); s.reti = 1; s.jmp = 1; s.jt = 24'o00007777; run(s);
    // ei and di together: di wins, no entry.
    bus.irq = 24'h800000;
    s = blank(); s.ei = 1; s.di = 1; run(s);
    // Request disappears in the IRQ cycle.
    s = blank(); s.ei = 1; s.irq_drop = 1; run(s);
    s = blank(); s.di = 1; run(s);
    // IP wrap from all-ones.
    s = blank(); s.jmp = 1; s.jt = 24'o77777777; run(s);
    s = blank(); run(s);
    s = blank(); s.has_imm = 1; s.imm_data = 12'o0001; s.jmp = 1; s.jt = 24'o77777777; run(s);
    s = blank(); s.has_imm = 1; s.imm_data = 12'o0002; run(s);
    // All lines requesting.
    bus.irq = 24'hFFFFFF;
    s = blank(); s.ei = 1; run(s);
    s = blank(); s.reti = 1; run(s);
    bus.irq = 24'd0;
    s = blank(); s.di = 1; run(s);

    // Random programs.
    for (int n = 0; n < 80; n++) begin
      s = blank();
      s.has_imm = 1'($urandom); s.acc = 1'($urandom); s.wr = 1'($urandom);
      s.reti = ($urandom_range(0, 7) == 0); s.ei = ($urandom_range(0, 3) == 0);
      s.di = ($urandom_range(0, 5) == 0); s.jmp = ($urandom_range(0, 3) == 0);
      s.jt = ($urandom_range(0, 3) == 0) ? 24'o77777776 + 24'($urandom_range(0, 1)) : 24'($urandom);
      s.pwe = 1'($urandom); s.phalf = 1'($urandom); s.pwd = 12'($urandom);
      s.dps = 2'($urandom_range(0, 3)); s.psel = 2'($urandom_range(0, 3));
      s.imm_data = 12'($urandom); s.irq_drop = ($urandom_range(0, 5) == 0);
      s.wf = $urandom_range(0, 2); s.wi = $urandom_range(0, 2); s.we = $urandom_range(0, 2);
      bus.irq = ($urandom_range(0, 3) == 0) ? (24'd1 << $urandom_range(0, 23)) : 24'd0;
      run(s);
    end
    bus.irq = 24'd0;

    // Reset in the middle of a store.
    s = blank(); s.jmp = 1; s.jt = 24'o00000500; run(s);
    s = blank(); s.acc = 1; s.wr = 1; s.we = 2; s.abort = 1; run(s);
    s = blank(); s.has_imm = 1; s.imm_data = 12'o4321; run(s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
